idu_decode_queue: RTL and testbench

Parametrised decode-and-buffer stage between IFU and EXU. It accepts raw instructions over a valid/ready handshake and decodes opcode, funct3 and funct7 into an `INST_NUM_WIDTH` instruction number, with an illegal flag. Decoded entries sit in a DEPTH-entry circular queue, so fetch and execute are decoupled. It replaces the purely combinational per-opcode funct3 muxes with one registered, back-pressured stage.

---
 rtl/idu_decode_queue.sv | 273 +++++++++++++++++++++++++++
 tb/tb_idu_decode_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_queue.sv
// Decode-and-buffer stage between IFU and EXU: RV32I decode into an instruction number and a DEPTH-entry queue.
// Define IDU_RV32M_EN to also decode the RV32M multiply/divide group. DEPTH must be a power of two and at least 2.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 6
`endif

module idu_decode_queue #(
    parameter int unsigned ISA_WIDTH = `ISA_WIDTH,
    parameter int unsigned NUM_WIDTH = `INST_NUM_WIDTH,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ISA_WIDTH-1:0]     in_inst,
    input  logic [ISA_WIDTH-1:0]     in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_WIDTH-1:0]     out_inst_num,
    output logic [ISA_WIDTH-1:0]     out_inst,
    output logic [ISA_WIDTH-1:0]     out_pc,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Opcode map
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Instruction-number encodings (same numbering as inst.vh)
    localparam logic [NUM_WIDTH-1:0] I_INV    = NUM_WIDTH'(0);
    localparam logic [NUM_WIDTH-1:0] I_LUI    = NUM_WIDTH'(1);
    localparam logic [NUM_WIDTH-1:0] I_AUIPC  = NUM_WIDTH'(2);
    localparam logic [NUM_WIDTH-1:0] I_JAL    = NUM_WIDTH'(3);
    localparam logic [NUM_WIDTH-1:0] I_JALR   = NUM_WIDTH'(4);
    localparam logic [NUM_WIDTH-1:0] I_BEQ    = NUM_WIDTH'(5);
    localparam logic [NUM_WIDTH-1:0] I_BNE    = NUM_WIDTH'(6);
    localparam logic [NUM_WIDTH-1:0] I_BLT    = NUM_WIDTH'(7);
    localparam logic [NUM_WIDTH-1:0] I_BGE    = NUM_WIDTH'(8);
    localparam logic [NUM_WIDTH-1:0] I_BLTU   = NUM_WIDTH'(9);
    localparam logic [NUM_WIDTH-1:0] I_BGEU   = NUM_WIDTH'(10);
    localparam logic [NUM_WIDTH-1:0] I_LB     = NUM_WIDTH'(11);
    localparam logic [NUM_WIDTH-1:0] I_LH     = NUM_WIDTH'(12);
    localparam logic [NUM_WIDTH-1:0] I_LW     = NUM_WIDTH'(13);
    localparam logic [NUM_WIDTH-1:0] I_LBU    = NUM_WIDTH'(14);
    localparam logic [NUM_WIDTH-1:0] I_LHU    = NUM_WIDTH'(15);
    localparam logic [NUM_WIDTH-1:0] I_SB     = NUM_WIDTH'(16);
    localparam logic [NUM_WIDTH-1:0] I_SH     = NUM_WIDTH'(17);
    localparam logic [NUM_WIDTH-1:0] I_SW     = NUM_WIDTH'(18);
    localparam logic [NUM_WIDTH-1:0] I_ADDI   = NUM_WIDTH'(19);
    localparam logic [NUM_WIDTH-1:0] I_SLTI   = NUM_WIDTH'(20);
    localparam logic [NUM_WIDTH-1:0] I_SLTIU  = NUM_WIDTH'(21);
    localparam logic [NUM_WIDTH-1:0] I_XORI   = NUM_WIDTH'(22);
    localparam logic [NUM_WIDTH-1:0] I_ORI    = NUM_WIDTH'(23);
    localparam logic [NUM_WIDTH-1:0] I_ANDI   = NUM_WIDTH'(24);
    localparam logic [NUM_WIDTH-1:0] I_SLLI   = NUM_WIDTH'(25);
    localparam logic [NUM_WIDTH-1:0] I_SRLI   = NUM_WIDTH'(26);
    localparam logic [NUM_WIDTH-1:0] I_SRAI   = NUM_WIDTH'(27);
    localparam logic [NUM_WIDTH-1:0] I_ADD    = NUM_WIDTH'(28);
    localparam logic [NUM_WIDTH-1:0] I_SUB    = NUM_WIDTH'(29);
    localparam logic [NUM_WIDTH-1:0] I_SLL    = NUM_WIDTH'(30);
    localparam logic [NUM_WIDTH-1:0] I_SLT    = NUM_WIDTH'(31);
    localparam logic [NUM_WIDTH-1:0] I_SLTU   = NUM_WIDTH'(32);
    localparam logic [NUM_WIDTH-1:0] I_XOR    = NUM_WIDTH'(33);
    localparam logic [NUM_WIDTH-1:0] I_SRL    = NUM_WIDTH'(34);
    localparam logic [NUM_WIDTH-1:0] I_SRA    = NUM_WIDTH'(35);
    localparam logic [NUM_WIDTH-1:0] I_OR     = NUM_WIDTH'(36);
    localparam logic [NUM_WIDTH-1:0] I_AND    = NUM_WIDTH'(37);
    localparam logic [NUM_WIDTH-1:0] I_EBREAK = NUM_WIDTH'(38);
`ifdef IDU_RV32M_EN
    localparam logic [NUM_WIDTH-1:0] I_MUL    = NUM_WIDTH'(39);
    localparam logic [NUM_WIDTH-1:0] I_MULH   = NUM_WIDTH'(40);
    localparam logic [NUM_WIDTH-1:0] I_MULHSU = NUM_WIDTH'(41);
    localparam logic [NUM_WIDTH-1:0] I_MULHU  = NUM_WIDTH'(42);
    localparam logic [NUM_WIDTH-1:0] I_DIV    = NUM_WIDTH'(43);
    localparam logic [NUM_WIDTH-1:0] I_DIVU   = NUM_WIDTH'(44);
    localparam logic [NUM_WIDTH-1:0] I_REM    = NUM_WIDTH'(45);
    localparam logic [NUM_WIDTH-1:0] I_REMU   = NUM_WIDTH'(46);
`endif

    typedef struct packed {
        logic [NUM_WIDTH-1:0] num;
        logic                 illegal;
        logic [ISA_WIDTH-1:0] inst;
        logic [ISA_WIDTH-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_e;

    occ_e               state, state_n;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    entry_t             mem [DEPTH];
    entry_t             head;
    logic [NUM_WIDTH-1:0] dec_num;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               push, pop;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Instruction decode; anything unmatched stays I_INV
    always_comb begin
        dec_num = I_INV;
        case (opcode)
            OPC_LUI:   dec_num = I_LUI;
            OPC_AUIPC: dec_num = I_AUIPC;
            OPC_JAL:   dec_num = I_JAL;
            OPC_JALR:  dec_num = (funct3 == 3'b000) ? I_JALR : I_INV;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_num = I_BEQ;
                    3'b001:  dec_num = I_BNE;
                    3'b100:  dec_num = I_BLT;
                    3'b101:  dec_num = I_BGE;
                    3'b110:  dec_num = I_BLTU;
                    3'b111:  dec_num = I_BGEU;
                    default: dec_num = I_INV;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  dec_num = I_LB;
                    3'b001:  dec_num = I_LH;
                    3'b010:  dec_num = I_LW;
                    3'b100:  dec_num = I_LBU;
                    3'b101:  dec_num = I_LHU;
                    default: dec_num = I_INV;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  dec_num = I_SB;
                    3'b001:  dec_num = I_SH;
                    3'b010:  dec_num = I_SW;
                    default: dec_num = I_INV;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000:  dec_num = I_ADDI;
                    3'b010:  dec_num = I_SLTI;
                    3'b011:  dec_num = I_SLTIU;
                    3'b100:  dec_num = I_XORI;
                    3'b110:  dec_num = I_ORI;
                    3'b111:  dec_num = I_ANDI;
                    3'b001:  dec_num = I_SLLI;
                    default: dec_num = funct7[5] ? I_SRAI : I_SRLI;
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
`ifdef IDU_RV32M_EN
                    case (funct3)
                        3'b000:  dec_num = I_MUL;
                        3'b001:  dec_num = I_MULH;
                        3'b010:  dec_num = I_MULHSU;
                        3'b011:  dec_num = I_MULHU;
                        3'b100:  dec_num = I_DIV;
                        3'b101:  dec_num = I_DIVU;
                        3'b110:  dec_num = I_REM;
                        default: dec_num = I_REMU;
                    endcase
`else
                    dec_num = I_INV;
`endif
                end else begin
                    case (funct3)
                        3'b000:  dec_num = funct7[5] ? I_SUB : I_ADD;
                        3'b001:  dec_num = I_SLL;
                        3'b010:  dec_num = I_SLT;
                        3'b011:  dec_num = I_SLTU;
                        3'b100:  dec_num = I_XOR;
                        3'b101:  dec_num = funct7[5] ? I_SRA : I_SRL;
                        3'b110:  dec_num = I_OR;
                        default: dec_num = I_AND;
                    endcase
                end
            end
            OPC_SYSTEM: dec_num = (in_inst == ISA_WIDTH'(32'h0010_0073)) ? I_EBREAK : I_INV;
            default:    dec_num = I_INV;
        endcase
    end

    // Handshakes depend only on registered occupancy, never on out_ready
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            cnt    <= cnt_n;
        end
    end

    // Next occupancy; flush overrides any same-cycle push or pop
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        cnt_n    = cnt;
        if (flush) begin
            state_n  = ST_EMPTY;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            cnt_n    = '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt_n = cnt + CNT_W'(1);
            else if (pop && !push) cnt_n = cnt - CNT_W'(1);
            if (cnt_n == '0)                 state_n = ST_EMPTY;
            else if (cnt_n == CNT_W'(DEPTH)) state_n = ST_FULL;
            else                             state_n = ST_PARTIAL;
        end
    end

    // Payload storage needs no reset: it is only observed while occupied
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr].num     <= dec_num;
            mem[wr_ptr].illegal <= (dec_num == I_INV);
            mem[wr_ptr].inst    <= in_inst;
            mem[wr_ptr].pc      <= in_pc;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_inst_num = I_INV;
        out_illegal  = 1'b0;
        out_inst     = '0;
        out_pc       = '0;
        if (state != ST_EMPTY) begin
            out_inst_num = head.num;
            out_illegal  = head.illegal;
            out_inst     = head.inst;
            out_pc       = head.pc;
        end
    end

endmodule

// File: tb/tb_idu_decode_queue.sv
// Testbench for idu_decode_queue: scenario tasks plus a scoreboard that tracks every accepted beat to its pop.
module tb_idu_decode_queue;

    localparam logic [5:0] E_INV = 6'd0,  E_LUI = 6'd1,  E_AUIPC = 6'd2, E_JAL = 6'd3,
                           E_JALR = 6'd4, E_BEQ = 6'd5,  E_BNE = 6'd6,   E_BLTU = 6'd9,
                           E_LW = 6'd13,  E_LBU = 6'd14, E_SW = 6'd18,   E_ADDI = 6'd19,
                           E_SLLI = 6'd25, E_SRLI = 6'd26, E_SRAI = 6'd27, E_ADD = 6'd28,
                           E_SUB = 6'd29, E_SRA = 6'd35, E_AND = 6'd37,  E_EBREAK = 6'd38;
`ifdef IDU_RV32M_EN
    localparam logic [5:0] E_MUL = 6'd39, E_DIV = 6'd43;
`else
    localparam logic [5:0] E_MUL = 6'd0,  E_DIV = 6'd0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [5:0]  out_inst_num;
    logic [2:0]  count;
    logic [5:0]  drv_num;

    typedef struct packed {
        logic [5:0]  num;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pops  = 0;

    idu_decode_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst_num(out_inst_num),
        .out_inst(out_inst), .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic set_beat(input logic [31:0] inst, input logic [31:0] pc, input logic [5:0] num);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        drv_num  = num;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_inst  = 32'h0;
        in_pc    = 32'h0;
        drv_num  = E_INV;
    endtask

    // Records accepted beats and checks each pop against the oldest expectation
    task automatic sb_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst || flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_tests++;
                    n_pops++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_pop: got unexpected pop inst=%h required none", out_inst);
                    end else begin
                        e = sb.pop_front();
                        if (out_inst_num !== e.num || out_inst !== e.inst || out_pc !== e.pc ||
                            out_illegal !== (e.num == E_INV)) begin
                            n_fail++;
                            $display("FAIL sb_pop: got num=%0d inst=%h pc=%h ill=%b required num=%0d inst=%h pc=%h ill=%b",
                                     out_inst_num, out_inst, out_pc, out_illegal,
                                     e.num, e.inst, e.pc, (e.num == E_INV));
                        end
                    end
                end
                if (in_valid && in_ready) sb.push_back('{drv_num, in_inst, in_pc});
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_illegal !== 1'b0 ||
            out_inst_num !== E_INV || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b cnt=%0d ill=%b num=%0d inst=%h pc=%h required 1 0 0 0 0 0 0",
                     in_ready, out_valid, count, out_illegal, out_inst_num, out_inst, out_pc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_push();
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_beat(32'h0050_0093, 32'h8000_0000, E_ADDI);
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || out_inst_num !== E_ADDI || out_pc !== 32'h8000_0000 ||
            out_illegal !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: got vld=%b num=%0d pc=%h ill=%b cnt=%0d required 1 %0d 80000000 0 1",
                     out_valid, out_inst_num, out_pc, out_illegal, count, E_ADDI);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_inst_num !== E_ADDI || out_inst !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL head_stable: got vld=%b num=%0d inst=%h required 1 %0d 00500093",
                     out_valid, out_inst_num, out_inst, E_ADDI);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got cnt=%0d vld=%b required 0 0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [3] = '{32'h4010_d093, 32'h4000_0033, 32'h0010_0073};
        logic [5:0]  nums  [3] = '{E_SRAI, E_SUB, E_EBREAK};
        int          base = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_beat(insts[i], 32'h100 + 32'(i * 4), nums[i]);
            @(posedge clk); #1;
            n_tests++;
            if (count !== 3'd1) begin
                n_fail++;
                $display("FAIL b2b_count[%0d]: got %0d required 1", i, count);
            end
        end
        idle();
        @(posedge clk); #1;
        n_tests++;
        if (count !== 3'd0 || n_pops - base != 3) begin
            n_fail++;
            $display("FAIL b2b_pops: got cnt=%0d pops=%0d required 0 3", count, n_pops - base);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [31:0] insts [5] = '{32'h1234_50b7, 32'h0000_0117, 32'h0080_00ef, 32'h0020_8463, 32'h0000_a103};
        logic [5:0]  nums  [5] = '{E_LUI, E_AUIPC, E_JAL, E_BEQ, E_LW};
        int          base = n_pops;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_beat(insts[i], 32'h200 + 32'(i * 4), nums[i]);
            @(posedge clk); #1;
        end
        n_tests++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_inst_num !== E_LUI) begin
            n_fail++;
            $display("FAIL full_state: got cnt=%0d rdy=%b num=%0d required 4 0 %0d",
                     count, in_ready, out_inst_num, E_LUI);
        end
        set_beat(insts[4], 32'h210, nums[4]);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: got cnt=%0d rdy=%b required 4 0", count, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_inst_num !== E_AUIPC) begin
            n_fail++;
            $display("FAIL full_pop_no_push: got cnt=%0d rdy=%b num=%0d required 3 1 %0d",
                     count, in_ready, out_inst_num, E_AUIPC);
        end
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL push_pop_hold: got cnt=%0d required 3", count);
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (count !== 3'd0 || n_pops - base != 5) begin
            n_fail++;
            $display("FAIL wrap_drain: got cnt=%0d pops=%0d required 0 5", count, n_pops - base);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        set_beat(32'h0000_0000, 32'h300, E_INV);
        @(posedge clk); #1;
        set_beat(32'h0020_0073, 32'h304, E_INV);
        n_tests++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_inst_num !== E_INV) begin
            n_fail++;
            $display("FAIL illegal_zero: got vld=%b ill=%b num=%0d required 1 1 0",
                     out_valid, out_illegal, out_inst_num);
        end
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL illegal_queued: got cnt=%0d required 2", count);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_rv32m();
        out_ready = 1'b0;
        set_beat(32'h0200_0033, 32'h400, E_MUL);
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (out_inst_num !== E_MUL || out_illegal !== (E_MUL == E_INV)) begin
            n_fail++;
            $display("FAIL rv32m_mul: got num=%0d ill=%b required %0d %b",
                     out_inst_num, out_illegal, E_MUL, (E_MUL == E_INV));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_decode_table();
        logic [31:0] insts [12] = '{32'h0000_8067, 32'h0000_1067, 32'h0020_a023, 32'h0010_9093,
                                    32'h0010_d093, 32'h0020_81b3, 32'h4020_d1b3, 32'h0020_f1b3,
                                    32'h0020_9463, 32'h0020_e463, 32'h0000_c083, 32'h0000_b083};
        logic [5:0]  nums  [12] = '{E_JALR, E_INV, E_SW, E_SLLI, E_SRLI, E_ADD,
                                    E_SRA, E_AND, E_BNE, E_BLTU, E_LBU, E_INV};
        int          base = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_beat(insts[i], 32'h500 + 32'(i * 4), nums[i]);
            @(posedge clk); #1;
        end
        set_beat(32'h0200_4033, 32'h530, E_DIV);
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (n_pops - base != 13 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL decode_stream: got pops=%0d cnt=%0d required 13 0", n_pops - base, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(32'h0050_0093, 32'h600 + 32'(i * 4), E_ADDI);
            @(posedge clk); #1;
        end
        n_tests++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_prefill: got cnt=%0d required 3", count);
        end
        set_beat(32'h4000_0033, 32'h60c, E_SUB);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst_num !== E_INV) begin
            n_fail++;
            $display("FAIL flush_clear: got cnt=%0d vld=%b rdy=%b num=%0d required 0 0 1 0",
                     count, out_valid, in_ready, out_inst_num);
        end
        set_beat(32'h0000_0117, 32'h700, E_AUIPC);
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (out_inst_num !== E_AUIPC || out_pc !== 32'h700 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_restart: got num=%0d pc=%h cnt=%0d required %0d 00000700 1",
                     out_inst_num, out_pc, count, E_AUIPC);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_beat(32'h0010_0073, 32'h800, E_EBREAK);
        @(posedge clk); #1;
        set_beat(32'h0020_0073, 32'h804, E_INV);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        #1;
        sb.delete();
        n_tests++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || out_illegal !== 1'b0 ||
            out_inst_num !== E_INV || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got vld=%b cnt=%0d rdy=%b ill=%b num=%0d inst=%h pc=%h required 0 0 1 0 0 0 0",
                     out_valid, count, in_ready, out_illegal, out_inst_num, out_inst, out_pc);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        set_beat(32'h1234_50b7, 32'h900, E_LUI);
        @(posedge clk); #1;
        idle();
        n_tests++;
        if (out_inst_num !== E_LUI || out_pc !== 32'h900 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_restart: got num=%0d pc=%h cnt=%0d required %0d 00000900 1",
                     out_inst_num, out_pc, count, E_LUI);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        fork
            sb_monitor();
        join_none
        test_reset();
        test_single_push();
        test_back_to_back();
        test_full_wrap();
        test_illegal();
        test_rv32m();
        test_decode_table();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
